// File: rtl/mem_wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package mem_wb_arb_pkg;
  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;
  localparam int DEFAULT_TIMEOUT = 16;
  localparam int M0 = 0;
  localparam int M1 = 1;
endpackage

// File: rtl/mem_wb_arb_wdog.sv
// Slave-response watchdog: pulses expire when a strobe has waited TIMEOUT cycles.
module mem_wb_arb_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic run,
  input  logic ack,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // An ack in the same cycle beats the timeout.
  assign expire = run & ~ack & (cnt == LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)         cnt <= '0;
    else if (ack || expire) cnt <= '0;
    else if (run)           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one memory slave between CPU (m0) and DMA (m1).
module mem_wb_arbiter
  import mem_wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADR_W   = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [31:0]      m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [31:0]      m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic             s_ack_i,
  input  logic [31:0]      s_dat_i,
  output logic [1:0]       gnt_o,
  output logic             tmo_o
);
  arb_state_e state;
  logic [1:0] gnt_q;
  logic       rr_m1;
  logic       tmo_q;
  logic [1:0] req;
  logic       owned, own_m1, own_cyc, own_stb, own_we, stb_raw, expire;
  logic [3:0]       own_sel;
  logic [ADR_W-1:0] own_adr;
  logic [31:0]      own_dat;

  assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign owned   = (state == OWNED);
  assign own_m1  = gnt_q[M1];
  assign own_cyc = own_m1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own_m1 ? m1_stb_i : m0_stb_i;
  assign own_we  = own_m1 ? m1_we_i  : m0_we_i;
  assign own_sel = own_m1 ? m1_sel_i : m0_sel_i;
  assign own_adr = own_m1 ? m1_adr_i : m0_adr_i;
  assign own_dat = own_m1 ? m1_dat_i : m0_dat_i;
  assign stb_raw = owned & own_cyc & own_stb;

  assign s_cyc_o = owned & own_cyc;
  assign s_stb_o = stb_raw & ~expire;
  assign s_we_o  = owned & own_we;
  assign s_sel_o = owned ? own_sel : '0;
  assign s_adr_o = owned ? own_adr : '0;
  assign s_dat_o = owned ? own_dat : '0;

  assign m0_ack_o = owned & gnt_q[M0] & s_ack_i;
  assign m1_ack_o = owned & gnt_q[M1] & s_ack_i;
  assign m0_err_o = gnt_q[M0] & expire;
  assign m1_err_o = gnt_q[M1] & expire;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = gnt_q;
  assign tmo_o    = tmo_q;

  // Outside OWNED the counter is held clear, same as after an ack.
  mem_wb_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .run      (stb_raw),
    .ack      (s_ack_i | ~owned),
    .expire   (expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      gnt_q <= '0;
      rr_m1 <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (expire) tmo_q <= 1'b1;
      case (state)
        IDLE: if (|req) begin
          state <= OWNED;
          if (&req) gnt_q <= rr_m1 ? 2'b10 : 2'b01;
          else      gnt_q <= req;
        end
        OWNED: if (!own_cyc) begin
          state <= IDLE;
          gnt_q <= '0;
          rr_m1 <= ~own_m1;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_wb_arbiter.md
MEM_WB_ARBITER -- requirements
Module: mem_wb_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 16, bus cycles a strobed slave access may wait for ack; ADR_W, default 32, address width.
REQ-002 wb_clk_i  input  1  single clock; all state on its rising edge.
REQ-003 wb_rst_ni  input  1  asynchronous, active-low reset.
REQ-004 m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 (CPU) Wishbone controls.
REQ-005 m0_sel_i 4, m0_adr_i ADR_W, m0_dat_i 32  input  master 0 byte select, address, write data.
REQ-006 m0_ack_o, m0_err_o  output  1 each;  m0_dat_o  output  32  master 0 responses.
REQ-007 m1_* ports SHALL mirror REQ-004..006 for master 1 (housekeeping/DMA).
REQ-008 s_cyc_o, s_stb_o, s_we_o  output  1;  s_sel_o 4, s_adr_o ADR_W, s_dat_o 32  output  slave (memory) port.
REQ-009 s_ack_i  input  1;  s_dat_i  input  32  slave response.
REQ-010 gnt_o  output  2  one-hot current owner; tmo_o  output  1  sticky timeout flag.

Function
REQ-011 States SHALL be IDLE and OWNED; reset state IDLE.
REQ-012 Request: req[n] = mN_cyc_i & mN_stb_i, sampled in IDLE.
REQ-013 IDLE, one request: grant it; next edge -> OWNED, gnt_o registered one-hot.
REQ-014 IDLE, both requesting: grant the master not granted last (round-robin bit, reset favours m0).
REQ-015 Arbitration latency SHALL be exactly one cycle from request in IDLE to slave strobe.
REQ-016 OWNED: s_cyc/stb/we/sel/adr/dat_o SHALL equal the owner's inputs combinationally; non-owner sees ack=err=0.
REQ-017 s_ack_i SHALL route combinationally to owner's ack; s_dat_i to both mN_dat_o.
REQ-018 Grant SHALL persist while owner's cyc_i is high (bursts, back-to-back strobes keep ownership).
REQ-019 Owner cyc_i low in OWNED: s_cyc_o/s_stb_o low same cycle; next edge -> IDLE, round-robin bit updated; no re-grant in that cycle.
REQ-020 Watchdog: counts cycles with s_stb_o high and s_ack_i low; cleared on ack or IDLE.
REQ-021 Count reaching TIMEOUT-1 without ack: owner's err_o high for exactly one cycle, s_stb_o forced low that cycle, counter cleared, tmo_o set.
REQ-022 s_ack_i and timeout in same cycle: ack wins, no err, tmo_o unchanged.
REQ-023 tmo_o SHALL clear only on reset.
REQ-024 Counter width SHALL be $clog2(TIMEOUT)+1; no wrap before TIMEOUT.
REQ-025 s_ack_i while IDLE SHALL be ignored.

Reset
REQ-026 wb_rst_ni low SHALL asynchronously force IDLE, gnt_o=0, round-robin to m0, counter=0, tmo_o=0.
REQ-027 While in reset all s_*_o and mN_ack_o/err_o SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon it with no ack/err; first grant after release per REQ-013/014.

Structure
REQ-029 Package mem_wb_arb_pkg SHALL hold state enum, DEFAULT_TIMEOUT=16, master-index constants.
REQ-030 Watchdog SHALL be sub-module mem_wb_arb_wdog (inputs run, ack; output expire).

Verification
REQ-031 m0 read 0x10 alone -> gnt_o=01 one cycle later, m0_ack_o on slave ack, m0_dat_o=mem[4].
REQ-032 m0,m1 request same cycle after reset -> m0 first; after m0 drops cyc, m1 granted next arbitration.
REQ-033 m0 holds cyc over 3 write strobes while m1 requests -> gnt_o stays 01 for all 3 acks.
REQ-034 Slave never acks, TIMEOUT=16 -> owner err_o on 16th strobed cycle, tmo_o=1, grant released when cyc drops.
REQ-035 Ack on cycle 16 -> ack only, no err, tmo_o=0.
REQ-036 wb_rst_ni low mid-read -> outputs 0 immediately, no ack; post-reset m1-only request granted.
